// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART blocks.
//   state_t           transmitter FSM encoding
//   UART_DATA_BITS    default data bits per frame
//   UART_STOP_BITS    default stop bits per frame
//   UART_DIV_*        baudrate_generator divisors (50 MHz system clock),
//                     also used by the rs232 top-level rate-select decode
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  localparam int UART_DIV_115200 = 433;
  localparam int UART_DIV_57600  = 867;
  localparam int UART_DIV_38400  = 1301;
  localparam int UART_DIV_9600   = 5207;

endpackage

// File: rtl/baud_edge_detect.sv
// baud_edge_detect: one-flop rising-edge detector for the baud reference.
//   clk       system clock (same domain as baud_clk, so no synchronizer)
//   reset     asynchronous, active-low reset
//   baud_clk  baudrate_generator clk_out
//   tick      one-clk pulse on each rising edge of baud_clk
// History resets to 1 so a baud_clk already high at reset release does not
// produce a spurious tick.
module baud_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic baud_clk,
  output logic tick
);

  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= 1'b1;
    else        prev <= baud_clk;
  end

  assign tick = baud_clk & ~prev;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, LSB first, line idles high.
// Frame: start bit, DATA_BITS data bits, optional parity, STOP_BITS stop bits.
//   clk       system clock
//   reset     asynchronous, active-low reset (aborts any frame, tx high)
//   baud_clk  baudrate_generator clk_out; each rising edge is one bit period
//   tx_data   byte to send, latched when tx_valid && tx_ready
//   tx_valid  tx_data is valid
//   tx_ready  block can accept a byte (registered)
//   tx        serial line out (registered)
//   tx_busy   frame in progress
//   tx_done   one-cycle pulse on the final stop-bit tick
// Build option: define UART_TX_PARITY_EN to add a parity bit after the data
// bits (even parity, or odd when PARITY_ODD=1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int STOP_BITS  = UART_STOP_BITS,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  logic                 tick;
  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [CW-1:0]        bitcnt;
  logic                 stopcnt;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`endif

  baud_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .baud_clk (baud_clk),
    .tick     (tick)
  );

  assign tx_busy = (state != IDLE);

  // Each state advances only on tick; tx changes on the tick that starts
  // the corresponding bit, so every bit lasts exactly one tick period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
      shreg    <= '0;
      bitcnt   <= '0;
      stopcnt  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_valid && tx_ready) begin
            shreg    <= tx_data;
`ifdef UART_TX_PARITY_EN
            par      <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
            tx_ready <= 1'b0;
            state    <= WAIT;
          end
        end
        // The accept cycle is spent in IDLE, so a tick coincident with
        // accept is never seen here; the start bit waits for the next one.
        WAIT: if (tick) begin
          tx    <= 1'b0;
          state <= START;
        end
        START: if (tick) begin
          tx     <= shreg[0];
          shreg  <= shreg >> 1;
          bitcnt <= '0;
          state  <= DATA;
        end
        DATA: if (tick) begin
          if (bitcnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx      <= par;
            state   <= PARITY;
`else
            tx      <= 1'b1;
            stopcnt <= 1'b0;
            state   <= STOP;
`endif
          end else begin
            bitcnt <= bitcnt + 1'b1;
            tx     <= shreg[0];
            shreg  <= shreg >> 1;
          end
        end
        PARITY: if (tick) begin
          tx      <= 1'b1;
          stopcnt <= 1'b0;
          state   <= STOP;
        end
        STOP: if (tick) begin
          tx <= 1'b1;
          if (stopcnt == STOP_LAST) begin
            tx_done  <= 1'b1;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            stopcnt <= 1'b1;
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
